mmio_memory: RTL and testbench
==============================

Name: mmio_memory

Overview:
- Data-memory responder for seq_core's data port (read/write/address/data in/out).
- Drop-in replacement for the plain data memory.
- Lower address space is RAM. The top 16 words are memory-mapped peripheral registers: cycle counter, down-timer with interrupt, GPIO and scratch.
- Lets programs run on seq_core observe time and drive pins without core changes.

Parameters:
- A_BITS, default `A_BITS (macros.vh): address width.
- D_BITS, default `D_BITS (macros.vh): data width.
- GPIO_W, default 8: GPIO input and output width.
- IO_BASE, default 2**A_BITS-16: first I/O word. RAM occupies 0..IO_BASE-1.

Ports:
- clk  in  1  clock, all state on posedge.
- rst  in  1  asynchronous reset, active-low.
- read  in  1  read strobe, active 1.
- write  in  1  write strobe, active 1.
- address  in  A_BITS  word address.
- mem_data_in  in  D_BITS  write data from core.
- mem_data_out  out  D_BITS  read data to core.
- gpio_in  in  GPIO_W  asynchronous external inputs.
- gpio_out  out  GPIO_W  registered outputs.
- irq  out  1  timer-expired level interrupt.

Behaviour:
- Reset (rst=0, asynchronous):
  - All I/O registers, counters, gpio_out and irq go to 0.
  - Synchronizer flops go to 0.
  - RAM contents are not reset.
- Read path (combinational, zero latency):
  - mem_data_out = selected word while read=1; 0 while read=0.
  - Reads never change state; STATUS is not clear-on-read.
- Write path: takes effect on the posedge where write=1.
- read and write both 1 in one cycle: write performed; mem_data_out shows the pre-write value.
- Decode:
  - address < IO_BASE: RAM.
  - Otherwise offset = address-IO_BASE.
- Register map:
  - 0x0 CYCLE (RO): free-running, +1 every cycle after reset, wraps 2^D_BITS-1 to 0.
  - 0x1 TLOAD (RW): a write also loads TVALUE in the same edge.
  - 0x2 TCTRL (RW): bit0 EN, bit1 AUTO. Other bits read 0.
  - 0x3 TVALUE (RO): down-counter.
  - 0x4 STATUS: bit0 EXP, sticky. Write 1 to bit0 clears it; writing 0 has no effect.
  - 0x5 GPIO_OUT (RW): low GPIO_W bits; gpio_out = this register.
  - 0x6 GPIO_IN (RO): gpio_in through a 2-flop synchronizer. Value visible 2 edges after the pin changes.
  - 0x7 SCRATCH (RW).
  - 0x8-0xF: reserved. Read 0, writes ignored.
  - Writes to RO registers are ignored.
- Timer, evaluated each posedge while EN=1:
  - TVALUE>0: decrement.
  - TVALUE==0: set EXP. If AUTO=1, TVALUE<=TLOAD; if AUTO=0, clear EN and hold 0.
  - EN=0: TVALUE holds.
- irq = EXP (registered).
- Collisions:
  - TLOAD write while the timer is counting: the load wins over the decrement.
  - W1C of STATUS in the same edge as an expiry: set wins, EXP stays 1.
  - TCTRL write in the same edge as an expiry clearing EN: the written TCTRL value wins.
- Widths: all counters D_BITS, modulo arithmetic. Narrow registers zero-extended on read.

Decomposition:
- Package mmio_pkg holds register offset localparams (OFF_CYCLE..OFF_SCRATCH), TCTRL bit indices and the STATUS EXP bit index.
- One sub-module, mmio_timer: TLOAD/TCTRL/TVALUE/EXP state plus the load/decrement/expiry logic. Inputs: decoded write enables and write data. Outputs: register values and irq.
- RAM array, decode, CYCLE and GPIO stay in the top.

Test Plan:
- RAM access: write 0xA5 to address 3, then read address 3. mem_data_out=0xA5 same cycle; read=0 gives 0. Read+write of 0x5A to address 3 in one cycle shows 0xA5, next read 0x5A.
- Cycle counter: release reset, then read CYCLE at two reads N cycles apart. Difference = N. Write CYCLE with 0: no effect.
- One-shot timer: TLOAD=3, TCTRL=1. TVALUE reads 2,1,0 on following cycles. EXP/irq=1 on the 4th edge, TCTRL reads 0. W1C STATUS=1 drops irq next cycle.
- Auto-reload timer: TLOAD=2, TCTRL=3. irq sets, reload to 2. W1C timed to an expiry edge leaves EXP=1.
- GPIO: write GPIO_OUT=0x3C, then gpio_out=0x3C after the edge. Drive gpio_in=0x81; GPIO_IN reads 0x81 from the 2nd edge on, earlier value before.
- Reset mid-count: with the timer running and GPIO_OUT=0xFF, pulse rst=0 between edges. Immediately TVALUE=0, TCTRL=0, irq=0, gpio_out=0. Reserved offset 0xA reads 0 after a write.

Source files
------------

// File: rtl/mmio_pkg.sv
// Register map and bit positions shared by the MMIO data memory and its timer.
package mmio_pkg;
  localparam int DEF_A_BITS = 8;
  localparam int DEF_D_BITS = 16;

  localparam logic [3:0] OFF_CYCLE    = 4'h0;
  localparam logic [3:0] OFF_TLOAD    = 4'h1;
  localparam logic [3:0] OFF_TCTRL    = 4'h2;
  localparam logic [3:0] OFF_TVALUE   = 4'h3;
  localparam logic [3:0] OFF_STATUS   = 4'h4;
  localparam logic [3:0] OFF_GPIO_OUT = 4'h5;
  localparam logic [3:0] OFF_GPIO_IN  = 4'h6;
  localparam logic [3:0] OFF_SCRATCH  = 4'h7;

  localparam int TCTRL_W    = 2;
  localparam int TCTRL_EN   = 0;
  localparam int TCTRL_AUTO = 1;
  localparam int STATUS_EXP = 0;
endpackage

// File: rtl/mmio_timer.sv
// Down-timer: TLOAD/TCTRL/TVALUE plus sticky expiry flag driving irq.
module mmio_timer
  import mmio_pkg::*;
#(
  parameter int D_BITS = DEF_D_BITS
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               tload_we,
  input  logic               tctrl_we,
  input  logic               status_we,
  input  logic [D_BITS-1:0]  wdata,
  output logic [D_BITS-1:0]  tload,
  output logic [TCTRL_W-1:0] tctrl,
  output logic [D_BITS-1:0]  tvalue,
  output logic               irq
);
  logic [D_BITS-1:0]  tload_q, tload_d, tvalue_q, tvalue_d;
  logic [TCTRL_W-1:0] tctrl_q, tctrl_d;
  logic               exp_q, exp_d, expire;

  // Later assignments override earlier ones: software writes beat the
  // timer's own updates, except that an expiry beats a W1C of EXP.
  always_comb begin
    tload_d  = tload_q;
    tvalue_d = tvalue_q;
    tctrl_d  = tctrl_q;
    exp_d    = exp_q;
    expire   = tctrl_q[TCTRL_EN] && (tvalue_q == '0);
    if (tctrl_q[TCTRL_EN]) begin
      if (tvalue_q != '0)          tvalue_d = tvalue_q - D_BITS'(1);
      else if (tctrl_q[TCTRL_AUTO]) tvalue_d = tload_q;
      else                          tctrl_d[TCTRL_EN] = 1'b0;
    end
    if (status_we && wdata[STATUS_EXP]) exp_d = 1'b0;
    if (expire)                         exp_d = 1'b1;
    if (tctrl_we) tctrl_d = wdata[TCTRL_W-1:0];
    if (tload_we) begin
      tload_d  = wdata;
      tvalue_d = wdata;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tload_q  <= '0;
      tvalue_q <= '0;
      tctrl_q  <= '0;
      exp_q    <= 1'b0;
    end else begin
      tload_q  <= tload_d;
      tvalue_q <= tvalue_d;
      tctrl_q  <= tctrl_d;
      exp_q    <= exp_d;
    end
  end

  assign tload  = tload_q;
  assign tctrl  = tctrl_q;
  assign tvalue = tvalue_q;
  assign irq    = exp_q;
endmodule

// File: rtl/mmio_memory.sv
// Data memory for seq_core: RAM below IO_BASE, 16 peripheral registers above.
module mmio_memory
  import mmio_pkg::*;
#(
  parameter int A_BITS  = DEF_A_BITS,
  parameter int D_BITS  = DEF_D_BITS,
  parameter int GPIO_W  = 8,
  parameter int IO_BASE = 2**A_BITS - 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              read,
  input  logic              write,
  input  logic [A_BITS-1:0] address,
  input  logic [D_BITS-1:0] mem_data_in,
  output logic [D_BITS-1:0] mem_data_out,
  input  logic [GPIO_W-1:0] gpio_in,
  output logic [GPIO_W-1:0] gpio_out,
  output logic              irq
);
  localparam logic [3:0] IO_LO = 4'(IO_BASE);

  logic [D_BITS-1:0] ram_q [IO_BASE];

  logic              is_io, is_ram;
  logic [3:0]        off;
  logic              io_we;
  logic [D_BITS-1:0] cycle_q, cycle_d, scratch_q, scratch_d, rdata;
  logic [GPIO_W-1:0] gpio_q, gpio_d, sync1_q, sync1_d, sync2_q, sync2_d;
  logic [D_BITS-1:0] tload, tvalue;
  logic [TCTRL_W-1:0] tctrl;

  // IO_BASE's low nibble alone gives the offset inside the 16-word window.
  assign is_io  = address >= A_BITS'(IO_BASE);
  assign is_ram = !is_io;
  assign off    = address[3:0] - IO_LO;
  assign io_we  = write && is_io;

  always_ff @(posedge clk) begin
    if (write && is_ram) ram_q[address] <= mem_data_in;
  end

  always_comb begin
    cycle_d   = cycle_q + D_BITS'(1);
    scratch_d = (io_we && off == OFF_SCRATCH) ? mem_data_in : scratch_q;
    gpio_d    = (io_we && off == OFF_GPIO_OUT) ? mem_data_in[GPIO_W-1:0] : gpio_q;
    sync1_d   = gpio_in;
    sync2_d   = sync1_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cycle_q   <= '0;
      scratch_q <= '0;
      gpio_q    <= '0;
      sync1_q   <= '0;
      sync2_q   <= '0;
    end else begin
      cycle_q   <= cycle_d;
      scratch_q <= scratch_d;
      gpio_q    <= gpio_d;
      sync1_q   <= sync1_d;
      sync2_q   <= sync2_d;
    end
  end

  mmio_timer #(.D_BITS(D_BITS)) u_timer (
    .clk       (clk),
    .rst       (rst),
    .tload_we  (io_we && off == OFF_TLOAD),
    .tctrl_we  (io_we && off == OFF_TCTRL),
    .status_we (io_we && off == OFF_STATUS),
    .wdata     (mem_data_in),
    .tload     (tload),
    .tctrl     (tctrl),
    .tvalue    (tvalue),
    .irq       (irq)
  );

  // Reads see current flop state, so read+write returns the pre-write value.
  always_comb begin
    rdata = '0;
    if (is_ram) rdata = ram_q[address];
    else begin
      case (off)
        OFF_CYCLE:    rdata = cycle_q;
        OFF_TLOAD:    rdata = tload;
        OFF_TCTRL:    rdata = D_BITS'(tctrl);
        OFF_TVALUE:   rdata = tvalue;
        OFF_STATUS:   rdata = D_BITS'(irq);
        OFF_GPIO_OUT: rdata = D_BITS'(gpio_q);
        OFF_GPIO_IN:  rdata = D_BITS'(sync2_q);
        OFF_SCRATCH:  rdata = scratch_q;
        default:      rdata = '0;
      endcase
    end
    mem_data_out = read ? rdata : '0;
  end

  assign gpio_out = gpio_q;
endmodule

// File: tb/tb_mmio_memory.sv
// Directed bench for mmio_memory at default widths (A=8, D=16, IO_BASE=0xF0).
module tb_mmio_memory;
  logic        clk, rst, read, write;
  logic [7:0]  address;
  logic [15:0] mem_data_in, mem_data_out;
  logic [7:0]  gpio_in, gpio_out;
  logic        irq;
  int n_cmp = 0, n_err = 0;

  localparam logic [7:0] A_CYCLE = 8'hF0, A_TLOAD = 8'hF1, A_TCTRL = 8'hF2,
    A_TVALUE = 8'hF3, A_STATUS = 8'hF4, A_GOUT = 8'hF5, A_GIN = 8'hF6, A_RSV = 8'hFA;

  mmio_memory dut (
    .clk(clk), .rst(rst), .read(read), .write(write), .address(address),
    .mem_data_in(mem_data_in), .mem_data_out(mem_data_out),
    .gpio_in(gpio_in), .gpio_out(gpio_out), .irq(irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Called at a negedge; the write lands on the next posedge, returns at the following negedge.
  task automatic do_write(input logic [7:0] a, input logic [15:0] d);
    read = 1'b0; write = 1'b1; address = a; mem_data_in = d;
    @(negedge clk);
    write = 1'b0;
  endtask

  task automatic set_read(input logic [7:0] a);
    read = 1'b1; address = a;
    #1;
  endtask

  task automatic test_reset();
    #3;
    n_cmp++; if (gpio_out !== 8'h00) begin n_err++; $display("FAIL reset_gpio: got %h want 00", gpio_out); end
    n_cmp++; if (irq !== 1'b0) begin n_err++; $display("FAIL reset_irq: got %b want 0", irq); end
    set_read(A_TVALUE);
    n_cmp++; if (mem_data_out !== 16'h0) begin n_err++; $display("FAIL reset_tvalue: got %h want 0000", mem_data_out); end
    @(negedge clk); rst = 1'b1; read = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_ram();
    do_write(8'd3, 16'h00A5);
    set_read(8'd3);
    n_cmp++; if (mem_data_out !== 16'h00A5) begin n_err++; $display("FAIL ram_read: got %h want 00a5", mem_data_out); end
    read = 1'b0; #1;
    n_cmp++; if (mem_data_out !== 16'h0) begin n_err++; $display("FAIL ram_noread: got %h want 0000", mem_data_out); end
    read = 1'b1; write = 1'b1; mem_data_in = 16'h005A; #1;
    n_cmp++; if (mem_data_out !== 16'h00A5) begin n_err++; $display("FAIL ram_rw_old: got %h want 00a5", mem_data_out); end
    @(negedge clk); write = 1'b0; #1;
    n_cmp++; if (mem_data_out !== 16'h005A) begin n_err++; $display("FAIL ram_rw_new: got %h want 005a", mem_data_out); end
  endtask

  task automatic test_cycle();
    logic [15:0] c0, c1;
    set_read(A_CYCLE); c0 = mem_data_out;
    repeat (5) @(negedge clk);
    set_read(A_CYCLE); c1 = mem_data_out;
    n_cmp++; if (16'(c1 - c0) !== 16'd5) begin n_err++; $display("FAIL cycle_delta: got %0d want 5", 16'(c1 - c0)); end
    do_write(A_CYCLE, 16'h0000);
    set_read(A_CYCLE);
    n_cmp++; if (mem_data_out !== 16'(c1 + 16'd1)) begin n_err++; $display("FAIL cycle_ro: got %h want %h", mem_data_out, 16'(c1 + 16'd1)); end
  endtask

  task automatic test_oneshot();
    logic [15:0] ev [3] = '{16'd2, 16'd1, 16'd0};
    do_write(A_TLOAD, 16'd3);
    do_write(A_TCTRL, 16'd1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); set_read(A_TVALUE);
      n_cmp++; if (mem_data_out !== ev[i]) begin n_err++; $display("FAIL oneshot_tv%0d: got %0d want %0d", i, mem_data_out, ev[i]); end
    end
    n_cmp++; if (irq !== 1'b0) begin n_err++; $display("FAIL oneshot_irq_early: got %b want 0", irq); end
    @(negedge clk);
    n_cmp++; if (irq !== 1'b1) begin n_err++; $display("FAIL oneshot_irq: got %b want 1", irq); end
    set_read(A_STATUS);
    n_cmp++; if (mem_data_out !== 16'h1) begin n_err++; $display("FAIL oneshot_status: got %h want 0001", mem_data_out); end
    set_read(A_TCTRL);
    n_cmp++; if (mem_data_out !== 16'h0) begin n_err++; $display("FAIL oneshot_tctrl: got %h want 0000", mem_data_out); end
    do_write(A_STATUS, 16'h0001);
    n_cmp++; if (irq !== 1'b0) begin n_err++; $display("FAIL oneshot_w1c: got %b want 0", irq); end
  endtask

  task automatic test_auto();
    do_write(A_TLOAD, 16'd2);
    do_write(A_TCTRL, 16'd3);
    repeat (3) @(negedge clk);
    n_cmp++; if (irq !== 1'b1) begin n_err++; $display("FAIL auto_irq: got %b want 1", irq); end
    set_read(A_TVALUE);
    n_cmp++; if (mem_data_out !== 16'd2) begin n_err++; $display("FAIL auto_reload: got %0d want 2", mem_data_out); end
    repeat (2) @(negedge clk);
    do_write(A_STATUS, 16'h0001);  // lands on the next expiry edge
    n_cmp++; if (irq !== 1'b1) begin n_err++; $display("FAIL auto_w1c_collide: got %b want 1", irq); end
    do_write(A_STATUS, 16'h0001);
    n_cmp++; if (irq !== 1'b0) begin n_err++; $display("FAIL auto_w1c: got %b want 0", irq); end
    do_write(A_TLOAD, 16'd7);      // TVALUE was 1; load beats decrement
    set_read(A_TVALUE);
    n_cmp++; if (mem_data_out !== 16'd7) begin n_err++; $display("FAIL auto_load_wins: got %0d want 7", mem_data_out); end
    do_write(A_TCTRL, 16'd0);
  endtask

  task automatic test_tctrl_collide();
    do_write(A_TLOAD, 16'd1);
    do_write(A_TCTRL, 16'd1);
    @(negedge clk);
    do_write(A_TCTRL, 16'd1);      // same edge as the one-shot expiry
    set_read(A_TCTRL);
    n_cmp++; if (mem_data_out !== 16'd1) begin n_err++; $display("FAIL tctrl_collide: got %h want 0001", mem_data_out); end
    n_cmp++; if (irq !== 1'b1) begin n_err++; $display("FAIL tctrl_collide_irq: got %b want 1", irq); end
    do_write(A_TCTRL, 16'd0);
    do_write(A_STATUS, 16'h0001);
  endtask

  task automatic test_gpio();
    do_write(A_GOUT, 16'h003C);
    n_cmp++; if (gpio_out !== 8'h3C) begin n_err++; $display("FAIL gpio_out: got %h want 3c", gpio_out); end
    gpio_in = 8'h81;
    set_read(A_GIN);
    n_cmp++; if (mem_data_out !== 16'h0) begin n_err++; $display("FAIL gpio_in_0: got %h want 0000", mem_data_out); end
    @(negedge clk); set_read(A_GIN);
    n_cmp++; if (mem_data_out !== 16'h0) begin n_err++; $display("FAIL gpio_in_1: got %h want 0000", mem_data_out); end
    @(negedge clk); set_read(A_GIN);
    n_cmp++; if (mem_data_out !== 16'h0081) begin n_err++; $display("FAIL gpio_in_2: got %h want 0081", mem_data_out); end
  endtask

  task automatic test_reset_mid();
    do_write(A_GOUT, 16'h00FF);
    do_write(A_TLOAD, 16'd10);
    do_write(A_TCTRL, 16'd1);
    @(negedge clk);
    #1 rst = 1'b0;
    set_read(A_TVALUE);
    n_cmp++; if (mem_data_out !== 16'h0) begin n_err++; $display("FAIL rstmid_tvalue: got %h want 0000", mem_data_out); end
    set_read(A_TCTRL);
    n_cmp++; if (mem_data_out !== 16'h0) begin n_err++; $display("FAIL rstmid_tctrl: got %h want 0000", mem_data_out); end
    n_cmp++; if (gpio_out !== 8'h00 || irq !== 1'b0) begin n_err++; $display("FAIL rstmid_pins: got %h/%b want 00/0", gpio_out, irq); end
    #1 rst = 1'b1;
    @(negedge clk);
    set_read(8'd3);
    n_cmp++; if (mem_data_out !== 16'h005A) begin n_err++; $display("FAIL rstmid_ram_kept: got %h want 005a", mem_data_out); end
    do_write(A_RSV, 16'h1234);
    set_read(A_RSV);
    n_cmp++; if (mem_data_out !== 16'h0) begin n_err++; $display("FAIL reserved: got %h want 0000", mem_data_out); end
  endtask

  initial begin
    rst = 1'b0; read = 1'b0; write = 1'b0; address = '0; mem_data_in = '0; gpio_in = '0;
    test_reset();
    test_ram();
    test_cycle();
    test_oneshot();
    test_auto();
    test_tctrl_collide();
    test_gpio();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
